// File: rtl/online_mult_ctrl.sv
// Controller for a radix-2 online multiplier. It feeds operand digit pairs to
// two SDVM instances, flushes the online delay with zero digits, and tags each
// product digit.
module online_mult_ctrl #(
  parameter int Num_bits = 4,
  parameter int DELTA    = 3,
  localparam int CW      = $clog2(Num_bits + 1),
  localparam int FW      = $clog2(DELTA + 1)
) (
  input  logic          clk,
  input  logic          asyn_reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [1:0]    x_digit,
  input  logic [1:0]    y_digit,
  output logic          in_ready,
  output logic [1:0]    x_sel,
  output logic [1:0]    y_sel,
  output logic          sdvm_enable,
  output logic          out_valid,
  output logic [CW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic          err_digit
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] in_cnt_r;
  logic [CW-1:0] out_cnt_r;
  logic [FW-1:0] flush_cnt_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [CW-1:0] out_idx_r;
  logic          busy_r;
  logic          done_r;
  logic          err_digit_r;

  logic          accept_s;
  logic          in_flush_s;
  logic          emit_s;
  logic          bad_s;
  logic          sdvm_en_s;
  logic [1:0]    x_sel_s;
  logic [1:0]    y_sel_s;

  function automatic logic is_illegal(input logic [1:0] d);
    return (d == 2'b11);
  endfunction

  // The illegal encoding is neutralised to a zero digit so the datapath keeps running.
  function automatic logic [1:0] sanitize_digit(input logic [1:0] d);
    logic [1:0] r;
    if (is_illegal(d)) begin
      r = 2'b00;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Handshake, emit detection and SDVM digit selection
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    in_flush_s = (state_r == ST_FLUSH);
    emit_s     = (accept_s & (state_r == ST_RUN)) | in_flush_s;
    sdvm_en_s  = accept_s | in_flush_s;
    bad_s      = accept_s & (is_illegal(x_digit) | is_illegal(y_digit));
    if (accept_s) begin
      x_sel_s = sanitize_digit(x_digit);
      y_sel_s = sanitize_digit(y_digit);
    end else begin
      x_sel_s = 2'b00;
      y_sel_s = 2'b00;
    end
  end

  assign in_ready    = in_ready_r;
  assign x_sel       = x_sel_s;
  assign y_sel       = y_sel_s;
  assign sdvm_enable = sdvm_en_s;
  assign out_valid   = out_valid_r;
  assign out_idx     = out_idx_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_digit   = err_digit_r;

  // Operation sequencer with counters and registered status outputs
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_r     <= ST_IDLE;
      in_cnt_r    <= '0;
      out_cnt_r   <= '0;
      flush_cnt_r <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_digit_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_INIT;
            in_cnt_r    <= '0;
            out_cnt_r   <= '0;
            err_digit_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_INIT: begin
          if (accept_s) begin
            in_cnt_r <= in_cnt_r + CW'(1);
            if ((in_cnt_r + CW'(1)) == CW'(DELTA)) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_INIT;
            end
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            in_cnt_r <= in_cnt_r + CW'(1);
            if ((in_cnt_r + CW'(1)) == CW'(Num_bits)) begin
              state_r     <= ST_FLUSH;
              in_ready_r  <= 1'b0;
              flush_cnt_r <= '0;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_cnt_r <= flush_cnt_r + FW'(1);
          if (flush_cnt_r == FW'(DELTA - 1)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_FLUSH;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase

      if (bad_s) begin
        err_digit_r <= 1'b1;
      end

      // Product digits trail their emitting cycle by one, matching the SDVM select delay.
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_idx_r <= out_cnt_r;
        out_cnt_r <= out_cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_online_mult_ctrl.sv
// Randomised scoreboard bench for online_mult_ctrl: the driver predicts the
// cycle and index of every product digit, and a monitor checks the DUT against that queue.
module tb_online_mult_ctrl;
  localparam int N  = 4;
  localparam int D  = 3;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          asyn_reset;
  logic          start;
  logic          in_valid;
  logic [1:0]    x_digit;
  logic [1:0]    y_digit;
  logic          in_ready;
  logic [1:0]    x_sel;
  logic [1:0]    y_sel;
  logic          sdvm_enable;
  logic          out_valid;
  logic [CW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic          err_digit;

  online_mult_ctrl #(.Num_bits(N), .DELTA(D)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .start(start), .in_valid(in_valid),
    .x_digit(x_digit), .y_digit(y_digit), .in_ready(in_ready),
    .x_sel(x_sel), .y_sel(y_sel), .sdvm_enable(sdvm_enable),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done),
    .err_digit(err_digit)
  );

  typedef struct {
    int cyc;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   emitted = 0;
  bit   err_exp = 1'b0;
  bit   mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] expect_sel(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  function automatic logic [1:0] rand_digit();
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Product digit k leaves the datapath one cycle after the k-th emitting cycle.
  task automatic push_emit();
    exp_t e;
    e.cyc  = cyc + 1;
    e.idx  = emitted;
    e.last = (emitted == N - 1);
    exp_q.push_back(e);
    emitted++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_sdvm_enable"}, sdvm_enable, 0);
    check({tag, "_x_sel"}, x_sel, 0);
    check({tag, "_y_sel"}, y_sel, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_digit"}, err_digit, 0);
  endtask

  // Checks every cycle: out_valid/out_idx/done must match the predicted digit stream exactly.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, 1);
        check("out_idx", out_idx, e.idx);
        check("done_with_digit", done, e.last);
      end else begin
        check("out_valid_quiet", out_valid, 0);
        check("done_quiet", done, 0);
      end
    end
  end

  task automatic idle_cycle();
    start    = 1'b0;
    in_valid = $urandom_range(0, 1);
    x_digit  = rand_digit();
    y_digit  = rand_digit();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_sdvm_enable", sdvm_enable, 0);
    check("idle_x_sel", x_sel, 0);
    @(posedge clk);
    #1;
  endtask

  // dmode: 0 random digits, 1 all +1, 2 all -1. bad_x/bad_y: accept index carrying 2'b11 (-1 = none).
  task automatic run_op(input bit hold_start, input int stall_mode, input int bad_x,
                        input int bad_y, input int dmode, input bit rst_flush);
    int acc;
    int guard;
    int stall_left;
    logic v;
    logic [1:0] xd;
    logic [1:0] yd;
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("start_busy_idle", busy, 0);
    check("err_sticky", err_digit, err_exp);
    check("start_in_ready_idle", in_ready, 0);
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    err_exp    = 1'b0;
    emitted    = 0;
    acc        = 0;
    guard      = 0;
    stall_left = 2;
    while (acc < N && guard < 64) begin
      guard++;
      v = 1'b1;
      if (stall_mode == 1 && (acc == 1 || acc == D) && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else if (stall_mode == 2) begin
        v = ($urandom_range(0, 3) != 0);
      end
      xd = (dmode == 1) ? 2'b10 : (dmode == 2) ? 2'b01 : rand_digit();
      yd = (dmode == 1) ? 2'b10 : (dmode == 2) ? 2'b01 : rand_digit();
      if (acc == bad_x) xd = 2'b11;
      if (acc == bad_y) yd = 2'b11;
      if (!v && $urandom_range(0, 1) == 1) xd = 2'b11;
      in_valid = v;
      x_digit  = xd;
      y_digit  = yd;
      @(negedge clk);
      check("run_in_ready", in_ready, 1);
      check("run_busy", busy, 1);
      check("run_sdvm_enable", sdvm_enable, v);
      check("run_x_sel", x_sel, v ? expect_sel(xd) : 2'b00);
      check("run_y_sel", y_sel, v ? expect_sel(yd) : 2'b00);
      if (v) begin
        if (acc >= D) push_emit();
        if (xd == 2'b11 || yd == 2'b11) err_exp = 1'b1;
        acc++;
        stall_left = 2;
      end
      @(posedge clk);
      #1;
    end
    check("accepts_within_budget", acc, N);
    for (int f = 0; f < D; f++) begin
      if (rst_flush && f == 1) begin
        asyn_reset = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_flush");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        asyn_reset = 1'b1;
        start      = 1'b0;
        err_exp    = 1'b0;
        return;
      end
      in_valid = $urandom_range(0, 1);
      x_digit  = rand_digit();
      y_digit  = rand_digit();
      @(negedge clk);
      check("flush_in_ready", in_ready, 0);
      check("flush_sdvm_enable", sdvm_enable, 1);
      check("flush_x_sel", x_sel, 0);
      check("flush_y_sel", y_sel, 0);
      check("flush_busy", busy, 1);
      push_emit();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("done_busy", busy, 1);
    check("done_err_digit", err_digit, err_exp);
    check("done_in_ready", in_ready, 0);
    check("done_sdvm_enable", sdvm_enable, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bx;
    int by;
    asyn_reset = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    x_digit    = 2'b00;
    y_digit    = 2'b00;
    #2;
    check_reset_outputs("reset");
    start = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_clocked");
    start      = 1'b0;
    asyn_reset = 1'b1;
    mon_en     = 1'b1;
    idle_cycle();

    run_op(1'b0, 1, -1, -1, 1, 1'b0);
    idle_cycle();
    run_op(1'b0, 0, -1, -1, 1, 1'b0);
    idle_cycle();
    run_op(1'b0, 1, -1, -1, 0, 1'b0);
    idle_cycle();
    run_op(1'b0, 0, 1, -1, 0, 1'b0);
    idle_cycle();
    run_op(1'b0, 0, -1, 2, 0, 1'b1);
    idle_cycle();
    run_op(1'b0, 0, -1, -1, 0, 1'b0);
    run_op(1'b1, 0, -1, -1, 2, 1'b0);
    run_op(1'b1, 2, -1, -1, 2, 1'b0);
    run_op(1'b0, 2, -1, -1, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
      bx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      by = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 2 : 0, bx, by, 0,
             ($urandom_range(0, 9) == 0));
    end

    idle_cycle();
    idle_cycle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/online_mult_ctrl.md
ONLINE_MULT_CTRL -- requirements
Module: online_mult_ctrl

Interface
REQ-001 Parameter Num_bits, default 4: operand precision in radix-2 signed digits; SHALL be > DELTA.
REQ-002 Parameter DELTA, default 3: online delay in cycles; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 asyn_reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a multiplication; sampled in IDLE only.
REQ-006 in_valid  input  1  x_digit/y_digit carry a valid digit pair this cycle.
REQ-007 x_digit, y_digit  input  2 each  signed digit: 2'b10=+1, 2'b01=-1, 2'b00=0, 2'b11 illegal.
REQ-008 in_ready  output  1  controller accepts a digit pair this cycle.
REQ-009 x_sel, y_sel  output  2 each  digit_select to the two SDVM instances.
REQ-010 sdvm_enable  output  1  enable to SDVM digit_select delay registers and operand shift registers.
REQ-011 out_valid  output  1  one product digit is available from the datapath this cycle.
REQ-012 out_idx  output  clog2(Num_bits+1)  index (0 = most significant) of the product digit flagged by out_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on completion.
REQ-015 err_digit  output  1  sticky: an illegal digit 2'b11 was accepted in the current operation.

Function
REQ-016 FSM states: IDLE, INIT, RUN, FLUSH, DONE; state, counters and all registered outputs in registers.
REQ-017 IDLE: start=1 -> INIT, in_cnt cleared, err_digit cleared; start=0 -> stay; start while busy is ignored.
REQ-018 in_ready = 1 in INIT and RUN, 0 otherwise; accept = in_valid & in_ready.
REQ-019 On accept: sdvm_enable=1, x_sel=x_digit, y_sel=y_digit (combinational pass-through), in_cnt increments.
REQ-020 Accepted 2'b11 SHALL drive x_sel/y_sel=2'b00 for that operand and set err_digit; operation continues.
REQ-021 No accept in INIT/RUN (in_valid=0): sdvm_enable=0, x_sel=y_sel=2'b00, all counters hold (stall).
REQ-022 INIT -> RUN on the accept that makes in_cnt = DELTA; no product digits emitted during INIT.
REQ-023 RUN -> FLUSH on the accept that makes in_cnt = Num_bits.
REQ-024 FLUSH: in_ready=0, sdvm_enable=1, x_sel=y_sel=2'b00 (zero digits) every cycle for exactly DELTA cycles; -> DONE after the DELTA-th.
REQ-025 Emitting cycle = accept in RUN, or any FLUSH cycle; exactly Num_bits emitting cycles per operation.
REQ-026 out_valid SHALL assert the cycle after each emitting cycle (matches the SDVM one-cycle digit_select delay); out_idx = number of previously emitted digits, 0..Num_bits-1.
REQ-027 DONE: done=1 for one cycle, coincident with the final out_valid (out_idx=Num_bits-1); -> IDLE next cycle.
REQ-028 out_valid has no backpressure; consumer SHALL take each digit when flagged.
REQ-029 start in the DONE cycle ignored; a new operation may start from IDLE the following cycle.

Reset
REQ-030 asyn_reset low SHALL immediately force state=IDLE, in_cnt=0, out counter=0, out_idx=0, in_ready=0, sdvm_enable=0, x_sel=y_sel=2'b00, out_valid=0, busy=0, done=0, err_digit=0.
REQ-031 Reset asserted mid-operation aborts it; no done pulse; after release, operation begins only on a fresh start.
REQ-032 Reset release takes effect synchronously to clk; first state update on the first rising edge with asyn_reset high.

Verification
REQ-033 Defaults, start, in_valid held 1, digits +1/+1 each cycle -> busy 1 cycle after start; INIT 3 accepts no out_valid; out_valid at 4 consecutive cycles idx 0..3; done with idx 3; total 1+4+3+1 cycles.
REQ-034 Stall: in_valid low 2 cycles during RUN -> sdvm_enable=0, x_sel=y_sel=00, in_cnt and out_idx frozen, no out_valid for those cycles; sequence resumes unchanged.
REQ-035 x_digit=2'b11 on 2nd accept -> x_sel=00 that cycle, err_digit=1 until next start, done still pulses.
REQ-036 asyn_reset low during FLUSH cycle 2 -> all outputs at reset values that same cycle; no done; later start runs full clean operation.
REQ-037 start held high through busy and DONE -> ignored; new operation begins only from IDLE; digit -1/-1 maps x_sel=y_sel=2'b01.
REQ-038 Num_bits=8, DELTA=2 -> 2 INIT accepts, 6 RUN emits, 2 FLUSH emits, out_idx 0..7, exactly 8 out_valid.
